// File: rtl/hs_parallel_in.sv
// Handshake parallel input port: accepts bytes over dav_/rfd into a small FIFO
// that a CPU drains through the s_/ior_/iow_/a0 byte-wide bus.
module hs_parallel_in #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       s_,
    input  logic       ior_,
    input  logic       iow_,
    input  logic       a0,
    inout  wire  [7:0] d7_d0,
    input  logic [7:0] byte_in,
    input  logic       dav_,
    output logic       rfd
);

    typedef enum logic {H_IDLE, H_ACK} hs_state_t;

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    hs_state_t        state, state_nx;
    logic             dav_m, dav_s;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_nx;
    logic [7:0]       rbr;
    logic             rd, rd_q, wr, wr_q;
    logic             rd_start, wr_start;
    logic             full, empty, push, pop, flush;
    logic [1:0]       cnt_disp;
    logic [7:0]       head, status, bus_out;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign rd       = ~s_ & ~ior_;
    assign wr       = ~s_ & ~iow_;
    assign rd_start = rd & ~rd_q;
    // A simultaneous read strobe wins; the write is dropped entirely.
    assign wr_start = wr & ~wr_q & ~rd;

    assign push  = (state == H_IDLE) & ~dav_s & ~full;
    assign pop   = rd_start & a0 & ~empty;
    assign flush = wr_start & ~a0 & d7_d0[0];

    assign head = empty ? 8'h00 : mem[rd_ptr];

    always_comb begin
        cnt_disp = count[1:0];
        if (DEPTH > 4 && count > 3)
            cnt_disp = 2'b11;
    end

    assign status = {4'b0000, full, ~empty, cnt_disp};

    // On the first cycle of a buffer read RBR has not loaded yet, so the
    // head value goes straight to the bus; RBR covers the rest of the strobe.
    assign bus_out = a0 ? (rd_start ? head : rbr) : status;
    assign d7_d0   = rd ? bus_out : 8'hzz;

    always_comb begin
        count_nx = count;
        if (flush)
            count_nx = '0;
        else if (push && !pop)
            count_nx = count + 1'b1;
        else if (pop && !push)
            count_nx = count - 1'b1;
    end

    // Flush does not block the handshake: a push still moves the FSM to H_ACK.
    always_comb begin
        state_nx = state;
        case (state)
            H_IDLE: if (push)  state_nx = H_ACK;
            H_ACK:  if (dav_s) state_nx = H_IDLE;
            default:           state_nx = H_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dav_m  <= 1'b1;
            dav_s  <= 1'b1;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            state  <= H_IDLE;
            rfd    <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rbr    <= 8'h00;
        end else begin
            dav_m <= dav_;
            dav_s <= dav_m;
            rd_q  <= rd;
            wr_q  <= wr;
            state <= state_nx;
            rfd   <= (state_nx == H_IDLE) && (count_nx != FULL_CNT);
            count <= count_nx;
            if (rd_start && a0)
                rbr <= head;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push && !flush)
            mem[wr_ptr] <= byte_in;
    end

endmodule
